// File: rtl/cpu_seq.sv
// Fetch/decode/branch sequencer for a 16-bit CPU.
// Ports: clk/reset, memory (mem_cmd/mem_addr/read_data/mem_rdy), exec handshake, branch/link, halt.
module cpu_seq #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     read_data,
  input  logic            mem_rdy,
  output logic [1:0]      mem_cmd,
  output logic [PC_W-1:0] mem_addr,
  input  logic [1:0]      ex_mem_cmd,
  input  logic [PC_W-1:0] ex_mem_addr,
  input  logic            N,
  input  logic            V,
  input  logic            Z,
  input  logic [15:0]     rd_val,
  output logic [15:0]     ir,
  output logic [PC_W-1:0] pc,
  output logic            exec_start,
  input  logic            exec_done,
  output logic            link_we,
  output logic [PC_W-1:0] link_val,
  output logic            halted,
  input  logic            resume
);

  // Memory command encodings (MWRITE=2'b10 only ever arrives via ex_mem_cmd).
  localparam logic [1:0] MREAD = 2'b11;
  localparam logic [1:0] MNONE = 2'b01;

  typedef enum logic [2:0] {
    S_RST,
    S_IF,
    S_UPC,
    S_DEC,
    S_EX,
    S_BR,
    S_BL,
    S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [15:0]     r_ir;
  logic            w_ir_ld;

  logic [PC_W-1:0] w_sximm;
  logic [PC_W-1:0] w_pc_rel;
  logic [PC_W-1:0] w_pc_reg;
  logic            w_nv;
  logic            w_taken;
  logic            w_op_br;
  logic            w_op_bl;
  logic            w_op_hlt;
  logic            w_unused;

  // Only rd_val[PC_W-1:0] is a branch target.
  assign w_unused = &{1'b0, rd_val};

  // Offsets are relative to the already incremented pc.
  assign w_sximm  = PC_W'($signed(r_ir[7:0]));
  assign w_pc_rel = r_pc + w_sximm;
  assign w_pc_reg = rd_val[PC_W-1:0];

  assign w_op_br  = (r_ir[15:13] == 3'b001);
  assign w_op_bl  = (r_ir[15:13] == 3'b010);
  assign w_op_hlt = (r_ir[15:13] == 3'b111);

  assign w_nv = N ^ V;

  always_comb begin
    w_taken = 1'b0;
    case (r_ir[10:8])
      3'b000:  w_taken = 1'b1;
      3'b001:  w_taken = Z;
      3'b010:  w_taken = ~Z;
      3'b011:  w_taken = w_nv;
      3'b100:  w_taken = w_nv | Z;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_ld     = 1'b0;
    mem_cmd     = MNONE;
    mem_addr    = r_pc;
    exec_start  = 1'b0;
    link_we     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_RST: begin
        w_state_nxt = S_IF;
      end
      S_IF: begin
        mem_cmd = MREAD;
        if (mem_rdy) begin
          w_ir_ld     = 1'b1;
          w_state_nxt = S_UPC;
        end
      end
      S_UPC: begin
        w_pc_nxt    = r_pc + 1'b1;
        w_state_nxt = S_DEC;
      end
      S_DEC: begin
        unique case (1'b1)
          w_op_br:  w_state_nxt = S_BR;
          w_op_bl:  w_state_nxt = S_BL;
          w_op_hlt: w_state_nxt = S_HALT;
          default: begin
            exec_start  = 1'b1;
            w_state_nxt = S_EX;
          end
        endcase
      end
      S_EX: begin
        mem_cmd  = ex_mem_cmd;
        mem_addr = ex_mem_addr;
        if (exec_done) begin
          w_state_nxt = S_IF;
        end
      end
      S_BR: begin
        if (w_taken) begin
          w_pc_nxt = w_pc_rel;
        end
        w_state_nxt = S_IF;
      end
      S_BL: begin
        case (r_ir[12:11])
          2'b11: begin
            link_we  = 1'b1;
            w_pc_nxt = w_pc_rel;
          end
          2'b00: begin
            w_pc_nxt = w_pc_reg;
          end
          2'b10: begin
            link_we  = 1'b1;
            w_pc_nxt = w_pc_reg;
          end
          default: begin
            w_pc_nxt = r_pc;
          end
        endcase
        w_state_nxt = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          w_state_nxt = S_IF;
        end
      end
      default: begin
        w_state_nxt = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_ir <= 16'h0000;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ir_ld) begin
        r_ir <= read_data;
      end
    end
  end

  assign pc       = r_pc;
  assign ir       = r_ir;
  assign link_val = r_pc;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq with fetch-address and link-value scoreboards.
// Inputs change 1ns after posedge; monitors sample on negedge.
module tb_cpu_seq;

  localparam logic [1:0] MREAD  = 2'b11;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MNONE  = 2'b01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] read_data = '0;
  logic        mem_rdy = 1'b0;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [1:0]  ex_mem_cmd = MNONE;
  logic [8:0]  ex_mem_addr = '0;
  logic        N = 1'b0;
  logic        V = 1'b0;
  logic        Z = 1'b0;
  logic [15:0] rd_val = '0;
  logic [15:0] ir;
  logic [8:0]  pc;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic        link_we;
  logic [8:0]  link_val;
  logic        halted;
  logic        resume = 1'b0;

  cpu_seq #(.PC_W(9), .RESET_PC(9'd0)) dut (
    .clk(clk), .reset(reset),
    .read_data(read_data), .mem_rdy(mem_rdy),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .ex_mem_cmd(ex_mem_cmd), .ex_mem_addr(ex_mem_addr),
    .N(N), .V(V), .Z(Z), .rd_val(rd_val),
    .ir(ir), .pc(pc), .exec_start(exec_start),
    .exec_done(exec_done), .link_we(link_we),
    .link_val(link_val), .halted(halted), .resume(resume)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [8:0]  exp_fetch[$];
  logic [8:0]  exp_link[$];
  logic [8:0]  cur_pc;
  logic [15:0] last_ins;

  typedef struct {
    logic [15:0] ins;
    logic        n;
    logic        v;
    logic        z;
    int          off;
  } br_t;

  br_t tbl[11] = '{
    '{16'h2102, 1'b0, 1'b0, 1'b0, 0},
    '{16'h2102, 1'b0, 1'b0, 1'b1, 2},
    '{16'h2203, 1'b0, 1'b0, 1'b0, 3},
    '{16'h2203, 1'b0, 1'b0, 1'b1, 0},
    '{16'h2301, 1'b1, 1'b0, 1'b0, 1},
    '{16'h2301, 1'b1, 1'b1, 1'b0, 0},
    '{16'h24FE, 1'b0, 1'b0, 1'b1, -2},
    '{16'h2401, 1'b0, 1'b0, 1'b0, 0},
    '{16'h2501, 1'b0, 1'b0, 1'b1, 0},
    '{16'h2781, 1'b1, 1'b0, 1'b1, 0},
    '{16'h2080, 1'b0, 1'b0, 1'b0, -128}
  };

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mem_cmd === MREAD && mem_rdy === 1'b1) begin
      chk("fetch_q", 32'(exp_fetch.size() > 0), 1);
      if (exp_fetch.size() > 0) chk("fetch_addr", mem_addr, exp_fetch.pop_front());
    end
    if (link_we === 1'b1) begin
      chk("link_q", 32'(exp_link.size() > 0), 1);
      if (exp_link.size() > 0) chk("link_val", link_val, exp_link.pop_front());
    end
  end

  task automatic fetch(input logic [15:0] ins, input logic [8:0] a,
                       input int waits);
    int n = 0;
    while (mem_cmd !== MREAD && n < 20) begin
      tick;
      n++;
    end
    chk("if_cmd", mem_cmd, MREAD);
    chk("if_addr", mem_addr, a);
    mem_rdy = 1'b0;
    for (int i = 0; i < waits; i++) begin
      tick;
      chk("wait_cmd", mem_cmd, MREAD);
      chk("wait_addr", mem_addr, a);
      chk("wait_ir", ir, last_ins);
    end
    mem_rdy = 1'b1;
    read_data = ins;
    exp_fetch.push_back(a);
    tick;
    mem_rdy = 1'b0;
    chk("ir_ld", ir, ins);
    last_ins = ins;
  endtask

  task automatic ctl(input logic [15:0] ins, input logic [8:0] exp_pc,
                     input logic lnk, input int waits);
    fetch(ins, cur_pc, waits);
    tick;
    chk("upc_pc", pc, 9'(cur_pc + 9'd1));
    chk("dec_xs", exec_start, 0);
    if (lnk) exp_link.push_back(9'(cur_pc + 9'd1));
    tick;
    chk("ctl_mem", mem_cmd, MNONE);
    chk("ctl_lwe", link_we, lnk);
    tick;
    chk("ctl_pc", pc, exp_pc);
    chk("ctl_if", mem_cmd, MREAD);
    cur_pc = exp_pc;
  endtask

  initial begin
    cur_pc = 9'd0;
    last_ins = 16'h0000;
    reset = 1'b1;
    tick;
    tick;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_cmd", mem_cmd, MNONE);
    chk("rst_xs", exec_start, 0);
    chk("rst_lwe", link_we, 0);
    chk("rst_hlt", halted, 0);
    reset = 1'b0;
    tick;

    ctl(16'h2005, 9'd6, 1'b0, 0);

    for (int i = 0; i < 11; i++) begin
      N = tbl[i].n;
      V = tbl[i].v;
      Z = tbl[i].z;
      ctl(tbl[i].ins, 9'(cur_pc + 9'd1 + 9'(tbl[i].off)),
          1'b0, (i == 0) ? 3 : 0);
    end

    ctl(16'h5FFE, 9'(cur_pc - 9'd1), 1'b1, 0);
    rd_val = 16'hFE0B;
    ctl(16'h4000, 9'h00B, 1'b0, 0);
    ctl(16'h4800, 9'h00C, 1'b0, 0);
    rd_val = 16'h01FF;
    ctl(16'h5000, 9'h1FF, 1'b1, 0);
    ctl(16'h2001, 9'h001, 1'b0, 0);

    ex_mem_cmd = MWRITE;
    ex_mem_addr = 9'd7;
    exec_done = 1'b1;
    fetch(16'h8000, cur_pc, 0);
    tick;
    chk("ex_xs_dec", exec_start, 1);
    tick;
    exec_done = 1'b0;
    chk("ex_xs_ex", exec_start, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ex_cmd", mem_cmd, MWRITE);
      chk("ex_addr", mem_addr, 9'd7);
      tick;
    end
    chk("ex_cmd5", mem_cmd, MWRITE);
    exec_done = 1'b1;
    tick;
    exec_done = 1'b0;
    chk("ex_exit_cmd", mem_cmd, MREAD);
    chk("ex_exit_addr", mem_addr, 9'(cur_pc + 9'd1));
    cur_pc = 9'(cur_pc + 9'd1);

    fetch(16'hE000, cur_pc, 0);
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("hlt", halted, 1);
      chk("hlt_pc", pc, 9'(cur_pc + 9'd1));
      chk("hlt_cmd", mem_cmd, MNONE);
      tick;
    end
    resume = 1'b1;
    tick;
    resume = 1'b0;
    chk("res_hlt", halted, 0);
    chk("res_cmd", mem_cmd, MREAD);
    chk("res_addr", mem_addr, 9'(cur_pc + 9'd1));
    cur_pc = 9'(cur_pc + 9'd1);

    fetch(16'h0000, cur_pc, 0);
    tick;
    tick;
    chk("ex2_cmd", mem_cmd, MWRITE);
    tick;
    reset = 1'b1;
    tick;
    chk("rex_pc", pc, 0);
    chk("rex_ir", ir, 0);
    chk("rex_cmd", mem_cmd, MNONE);
    chk("rex_xs", exec_start, 0);
    chk("rex_hlt", halted, 0);
    reset = 1'b0;
    cur_pc = 9'd0;
    last_ins = 16'h0000;
    tick;
    chk("rif_cmd", mem_cmd, MREAD);
    reset = 1'b1;
    mem_rdy = 1'b1;
    read_data = 16'hFFFF;
    exp_fetch.push_back(9'd0);
    tick;
    mem_rdy = 1'b0;
    reset = 1'b0;
    chk("rif_ir", ir, 0);
    chk("rif_cmd2", mem_cmd, MNONE);
    tick;

    ctl(16'h2005, 9'd6, 1'b0, 0);

    chk("fetch_q_end", exp_fetch.size(), 0);
    chk("link_q_end", exp_link.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
